// File: rtl/alu_ctrl_md_seq_pkg.sv
// Shared constants for the ALU control / MUL-DIV sequencer.
//   ALU codes, FSM state encodings (2 bits), AluOp encodings from main control.
package alu_ctrl_md_seq_pkg;

    localparam logic [4:0] ALU_ADD = 5'b00000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] ALUOP_MEM   = 3'b000;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_ITYPE = 3'b011;

    // Pass-through form of the funct fields used by most decode rows.
    function automatic logic [4:0] raw_code(input logic f70, input logic f75,
                                            input logic [2:0] f3);
        return {f70, f75, f3};
    endfunction

endpackage

// File: rtl/alu_ctrl_md_seq_decode.sv
// Combinational ALU-code decode.
//   i_alu_op/i_op5/i_f70/i_f75/i_f3 : main-control AluOp, opcode bit 5, funct fields
//   o_code    : 5-bit ALU code (ADD when an M op is illegal)
//   o_is_md   : M-extension op routed to the MD unit
//   o_illegal : M-extension op seen while the M extension is disabled
module alu_ctrl_md_seq_decode
    import alu_ctrl_md_seq_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [2:0] i_alu_op,
    input  logic       i_op5,
    input  logic       i_f70,
    input  logic       i_f75,
    input  logic [2:0] i_f3,
    output logic [4:0] o_code,
    output logic       o_is_md,
    output logic       o_illegal
);

    logic [4:0] w_code;
    logic       w_m_class;

    always_comb begin
        w_code    = raw_code(i_f70, i_f75, i_f3);
        w_m_class = 1'b0;
        casez ({i_alu_op, i_op5})
            {ALUOP_MEM, 1'b?}: w_code = ALU_ADD;
            {ALUOP_RTYPE, 1'b1}: begin
                w_code    = raw_code(i_f70, i_f75, i_f3);
                w_m_class = i_f70;
            end
            {ALUOP_ITYPE, 1'b0}: begin
                // Immediate ops: funct7[0] is part of the immediate, never meaningful.
                case (i_f3)
                    3'b000:  w_code = ALU_ADD;
                    3'b101:  w_code = {1'b0, i_f75, 3'b101};
                    default: w_code = {2'b00, i_f3};
                endcase
            end
            default: w_code = raw_code(i_f70, i_f75, i_f3);
        endcase
    end

    assign o_is_md   = w_m_class & ENABLE_M;
    assign o_illegal = w_m_class & ~ENABLE_M;
    assign o_code    = o_illegal ? ALU_ADD : w_code;

endmodule

// File: rtl/alu_ctrl_md_seq.sv
// ALU control at the ID/EX boundary with RV32M multi-cycle sequencing.
//   clk, rst        : clock, synchronous active-high reset
//   id_*            : decode-stage instruction fields and valid
//   ex_flush        : kill the EX-stage op (also aborts an in-flight MD op)
//   md_done         : MD unit result ready
//   ex_alu_ctrl/ex_valid/ex_is_md : registered EX-stage op
//   md_start/md_op/md_abort/md_timeout : MD unit handshake
//   stall           : hold IF/ID while an MD op is in ISSUE/WAIT
//   illegal         : M op decoded with the M extension disabled
//
//   state | meaning
//   IDLE  | no MD op in flight, accepting
//   ISSUE | start pulse to MD unit, stalling
//   WAIT  | waiting for md_done, counting toward timeout
//   DONE  | result cycle, accepting the next op
module alu_ctrl_md_seq
    import alu_ctrl_md_seq_pkg::*;
#(
    parameter int CTRL_W     = 5,
    parameter bit ENABLE_M   = 1'b1,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = $clog2(MD_TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_op5,
    input  logic              id_func70,
    input  logic              id_func75,
    input  logic [2:0]        id_func3,
    input  logic [2:0]        id_alu_op,
    input  logic              ex_flush,
    input  logic              md_done,
    output logic [CTRL_W-1:0] ex_alu_ctrl,
    output logic              ex_valid,
    output logic              ex_is_md,
    output logic              md_start,
    output logic [2:0]        md_op,
    output logic              md_abort,
    output logic              stall,
    output logic              md_timeout,
    output logic              illegal
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    logic [4:0]        w_code;
    logic              w_is_md;
    logic              w_illegal;
    logic              w_accept;
    logic              w_in_md;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CTRL_W-1:0] r_ex_alu_ctrl;
    logic              r_ex_valid;
    logic              r_ex_is_md;
    logic [2:0]        r_md_op;
    logic              r_md_timeout;
    logic              r_illegal;

    alu_ctrl_md_seq_decode #(.ENABLE_M(ENABLE_M)) u_decode (
        .i_alu_op  (id_alu_op),
        .i_op5     (id_op5),
        .i_f70     (id_func70),
        .i_f75     (id_func75),
        .i_f3      (id_func3),
        .o_code    (w_code),
        .o_is_md   (w_is_md),
        .o_illegal (w_illegal)
    );

    assign w_in_md  = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign w_accept = id_valid && !ex_flush && !w_in_md;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_ex_alu_ctrl <= '0;
            r_ex_valid    <= 1'b0;
            r_ex_is_md    <= 1'b0;
            r_md_op       <= 3'b000;
            r_md_timeout  <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            r_md_timeout <= 1'b0;
            r_illegal    <= 1'b0;
            if (ex_flush) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_ex_valid <= 1'b0;
                r_ex_is_md <= 1'b0;
            end else begin
                case (r_state)
                    ST_ISSUE: begin
                        r_cnt   <= '0;
                        r_state <= md_done ? ST_DONE : ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (md_done) begin
                            r_state <= ST_DONE;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state      <= ST_IDLE;
                            r_ex_valid   <= 1'b0;
                            r_ex_is_md   <= 1'b0;
                            r_md_timeout <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        // IDLE and DONE both accept; DONE may chain straight into ISSUE.
                        r_ex_valid <= w_accept;
                        r_ex_is_md <= w_accept && w_is_md;
                        r_state    <= (w_accept && w_is_md) ? ST_ISSUE : ST_IDLE;
                        if (w_accept) begin
                            r_ex_alu_ctrl <= CTRL_W'(w_code);
                            r_illegal     <= w_illegal;
                            if (w_is_md) r_md_op <= id_func3;
                        end
                    end
                endcase
            end
        end
    end

    assign ex_alu_ctrl = r_ex_alu_ctrl;
    assign ex_valid    = r_ex_valid;
    assign ex_is_md    = r_ex_is_md;
    assign md_op       = r_md_op;
    assign md_timeout  = r_md_timeout;
    assign illegal     = r_illegal;
    assign stall       = w_in_md;
    assign md_start    = (r_state == ST_ISSUE);
    // Abort must coincide with the flush so the MD unit drops the op in the same cycle.
    assign md_abort    = ex_flush && w_in_md;

endmodule

// File: tb/tb_alu_ctrl_md_seq.sv
module tb_alu_ctrl_md_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_op5, id_func70, id_func75, ex_flush, md_done;
    logic [2:0] id_func3, id_alu_op;

    logic [4:0] ex_alu_ctrl;
    logic       ex_valid, ex_is_md, md_start, md_abort, stall, md_timeout, illegal;
    logic [2:0] md_op;

    logic [5:0] o0_alu_ctrl;
    logic       o0_valid, o0_is_md, o0_start, o0_abort, o0_stall, o0_timeout, o0_illegal;
    logic [2:0] o0_md_op;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] code;
        logic [2:0] op;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    alu_ctrl_md_seq #(.CTRL_W(5), .ENABLE_M(1'b1), .MD_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op5(id_op5),
        .id_func70(id_func70), .id_func75(id_func75), .id_func3(id_func3),
        .id_alu_op(id_alu_op), .ex_flush(ex_flush), .md_done(md_done),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_valid(ex_valid), .ex_is_md(ex_is_md),
        .md_start(md_start), .md_op(md_op), .md_abort(md_abort), .stall(stall),
        .md_timeout(md_timeout), .illegal(illegal)
    );

    alu_ctrl_md_seq #(.CTRL_W(6), .ENABLE_M(1'b0), .MD_TIMEOUT(8)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op5(id_op5),
        .id_func70(id_func70), .id_func75(id_func75), .id_func3(id_func3),
        .id_alu_op(id_alu_op), .ex_flush(ex_flush), .md_done(md_done),
        .ex_alu_ctrl(o0_alu_ctrl), .ex_valid(o0_valid), .ex_is_md(o0_is_md),
        .md_start(o0_start), .md_op(o0_md_op), .md_abort(o0_abort), .stall(o0_stall),
        .md_timeout(o0_timeout), .illegal(o0_illegal)
    );

    function automatic logic [4:0] model_code(input logic [2:0] aop, input logic op5,
                                              input logic f70, input logic f75,
                                              input logic [2:0] f3);
        if (aop == 3'b000) return 5'b00000;
        if (aop == 3'b011 && !op5) begin
            if (f3 == 3'b000) return 5'b00000;
            if (f3 == 3'b101) return {1'b0, f75, 3'b101};
            return {2'b00, f3};
        end
        return {f70, f75, f3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] aop, input logic op5,
                         input logic f70, input logic f75, input logic [2:0] f3);
        id_valid  = v;
        id_alu_op = aop;
        id_op5    = op5;
        id_func70 = f70;
        id_func75 = f75;
        id_func3  = f3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
        ex_flush = 1'b0;
        md_done  = 1'b0;
        tick();
        tick();
        checks++;
        if ({ex_alu_ctrl, ex_valid, ex_is_md, stall, md_start, md_abort, md_timeout, illegal, md_op} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got alu=%b v=%b md=%b st=%b start=%b ab=%b to=%b ill=%b op=%b, want all 0",
                     ex_alu_ctrl, ex_valid, ex_is_md, stall, md_start, md_abort, md_timeout, illegal, md_op);
        end
        checks++;
        if ({o0_alu_ctrl, o0_valid, o0_stall, o0_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_nom: got alu=%b v=%b st=%b ill=%b, want all 0",
                     o0_alu_ctrl, o0_valid, o0_stall, o0_illegal);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_decode();
        logic [2:0] t_aop[5] = '{3'b010, 3'b011, 3'b011, 3'b000, 3'b011};
        logic       t_op5[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       t_f70[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       t_f75[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0] t_f3 [5] = '{3'b000, 3'b000, 3'b101, 3'b111, 3'b110};
        logic [4:0] t_exp[5] = '{5'b01000, 5'b00000, 5'b01101, 5'b00000, 5'b00110};
        exp_t e;
        for (int i = 0; i < 25; i++) begin
            logic [2:0] aop, f3;
            logic op5, f70, f75;
            if (i < 5) begin
                aop = t_aop[i]; op5 = t_op5[i]; f70 = t_f70[i]; f75 = t_f75[i]; f3 = t_f3[i];
                e.code = t_exp[i];
            end else begin
                aop = 3'($urandom_range(0, 7));
                op5 = 1'($urandom_range(0, 1));
                f70 = 1'($urandom_range(0, 1));
                f75 = 1'($urandom_range(0, 1));
                f3  = 3'($urandom_range(0, 7));
                if (aop == 3'b010 && op5) f70 = 1'b0;
                e.code = model_code(aop, op5, f70, f75, f3);
            end
            e.op = 3'b000;
            drive(1'b1, aop, op5, f70, f75, f3);
            sbq.push_back(e);
            tick();
            e = sbq.pop_front();
            checks++;
            if (ex_alu_ctrl !== e.code || ex_valid !== 1'b1 || stall !== 1'b0 || ex_is_md !== 1'b0) begin
                errors++;
                $display("FAIL decode[%0d]: got alu=%b v=%b st=%b md=%b, want alu=%b v=1 st=0 md=0",
                         i, ex_alu_ctrl, ex_valid, stall, ex_is_md, e.code);
            end
            checks++;
            if (o0_alu_ctrl !== {1'b0, e.code} || o0_illegal !== 1'b0) begin
                errors++;
                $display("FAIL decode_nom[%0d]: got alu=%b ill=%b, want alu=0%b ill=0",
                         i, o0_alu_ctrl, o0_illegal, e.code);
            end
        end
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_accept_valid: got %b want 0", ex_valid);
        end
    endtask

    task automatic test_mul();
        int n_stall = 0, n_start = 0;
        exp_t e;
        drive(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 3'b000);
        sbq.push_back('{code: 5'b10000, op: 3'b000});
        tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
        for (int c = 0; c < 9; c++) begin
            md_done = (c == 5);
            if (stall) n_stall++;
            if (md_start) n_start++;
            if (c == 0) begin
                checks++;
                if (md_start !== 1'b1 || ex_valid !== 1'b1 || ex_is_md !== 1'b1) begin
                    errors++;
                    $display("FAIL mul_issue: got start=%b v=%b md=%b want 1 1 1", md_start, ex_valid, ex_is_md);
                end
            end
            if (c == 6) begin
                e = sbq.pop_front();
                checks++;
                if (stall !== 1'b0 || ex_valid !== 1'b1 || ex_is_md !== 1'b1 ||
                    md_op !== e.op || ex_alu_ctrl !== e.code) begin
                    errors++;
                    $display("FAIL mul_done: got st=%b v=%b md=%b op=%b alu=%b want 0 1 1 %b %b",
                             stall, ex_valid, ex_is_md, md_op, ex_alu_ctrl, e.op, e.code);
                end
            end
            if (c == 7) begin
                checks++;
                if (ex_valid !== 1'b0 || ex_is_md !== 1'b0) begin
                    errors++;
                    $display("FAIL mul_after_done: got v=%b md=%b want 0 0", ex_valid, ex_is_md);
                end
            end
            tick();
        end
        md_done = 1'b0;
        checks++;
        if (n_stall != 6 || n_start != 1) begin
            errors++;
            $display("FAIL mul_counts: got stall_cycles=%0d start_cycles=%0d want 6 1", n_stall, n_start);
        end
    endtask

    task automatic test_timeout();
        int tmo_at = -1, n_tmo = 0;
        drive(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 3'b100);
        tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
        for (int c = 0; c < 14; c++) begin
            if (c == 8) begin
                checks++;
                if (stall !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_last_wait_stall: got %b want 1", stall);
                end
            end
            if (md_timeout) begin
                n_tmo++;
                if (tmo_at < 0) begin
                    tmo_at = c;
                    checks++;
                    if (stall !== 1'b0 || ex_valid !== 1'b0 || ex_is_md !== 1'b0) begin
                        errors++;
                        $display("FAIL tmo_outputs: got st=%b v=%b md=%b want 0 0 0", stall, ex_valid, ex_is_md);
                    end
                end
            end
            tick();
        end
        checks++;
        if (tmo_at != 9 || n_tmo != 1) begin
            errors++;
            $display("FAIL tmo_cycle: got cycle=%0d pulses=%0d want 9 1", tmo_at, n_tmo);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        drive(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 3'b110);
        sbq.push_back('{code: 5'b10110, op: 3'b110});
        tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
        e = sbq.pop_front();
        checks++;
        if (ex_alu_ctrl !== e.code || md_op !== e.op) begin
            errors++;
            $display("FAIL rem_issue: got alu=%b op=%b want %b %b", ex_alu_ctrl, md_op, e.code, e.op);
        end
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                checks++;
                if (md_abort !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_early: got %b want 0", md_abort);
                end
            end
            tick();
        end
        ex_flush = 1'b1;
        md_done  = 1'b1;
        #1;
        checks++;
        if (md_abort !== 1'b1) begin
            errors++;
            $display("FAIL abort_pulse: got %b want 1", md_abort);
        end
        tick();
        ex_flush = 1'b0;
        checks++;
        if (stall !== 1'b0 || ex_valid !== 1'b0 || ex_is_md !== 1'b0 || md_abort !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got st=%b v=%b md=%b ab=%b want 0 0 0 0", stall, ex_valid, ex_is_md, md_abort);
        end
        tick();
        md_done = 1'b0;
        checks++;
        if (stall !== 1'b0 || ex_valid !== 1'b0 || md_start !== 1'b0) begin
            errors++;
            $display("FAIL late_done_ignored: got st=%b v=%b start=%b want 0 0 0", stall, ex_valid, md_start);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 3'b000);
        tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        checks++;
        if (stall !== 1'b0 || ex_valid !== 1'b1 || md_op !== 3'b000) begin
            errors++;
            $display("FAIL b2b_first_done: got st=%b v=%b op=%b want 0 1 000", stall, ex_valid, md_op);
        end
        drive(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 3'b101);
        tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
        checks++;
        if (md_start !== 1'b1 || md_op !== 3'b101 || ex_alu_ctrl !== 5'b10101 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_issue: got start=%b op=%b alu=%b v=%b want 1 101 10101 1",
                     md_start, md_op, ex_alu_ctrl, ex_valid);
        end
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        tick();
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        checks++;
        if (stall !== 1'b0 || md_start !== 1'b0 || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_done_ignored: got st=%b start=%b v=%b want 0 0 0", stall, md_start, ex_valid);
        end
    endtask

    task automatic test_illegal();
        int n_start0 = 0;
        exp_t e;
        drive(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 3'b001);
        sbq.push_back('{code: 5'b00000, op: 3'b000});
        tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
        e = sbq.pop_front();
        if (o0_start) n_start0++;
        checks++;
        if (o0_illegal !== 1'b1 || o0_alu_ctrl !== {1'b0, e.code} || o0_valid !== 1'b1 ||
            o0_is_md !== 1'b0 || o0_stall !== 1'b0) begin
            errors++;
            $display("FAIL illegal_mulh: got ill=%b alu=%b v=%b md=%b st=%b want 1 0%b 1 0 0",
                     o0_illegal, o0_alu_ctrl, o0_valid, o0_is_md, o0_stall, e.code);
        end
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        if (o0_start) n_start0++;
        checks++;
        if (o0_illegal !== 1'b0 || o0_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse_end: got ill=%b v=%b want 0 0", o0_illegal, o0_valid);
        end
        tick();
        if (o0_start) n_start0++;
        checks++;
        if (n_start0 != 0) begin
            errors++;
            $display("FAIL illegal_no_start: got %0d start cycles want 0", n_start0);
        end
    endtask

    task automatic test_reset_wait();
        drive(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 3'b100);
        tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        tick();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_wait: got stall=%b want 1", stall);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ex_alu_ctrl, ex_valid, ex_is_md, stall, md_start, md_abort, md_timeout, illegal, md_op} !== '0) begin
            errors++;
            $display("FAIL reset_in_wait: got alu=%b v=%b md=%b st=%b start=%b ab=%b to=%b ill=%b op=%b, want all 0",
                     ex_alu_ctrl, ex_valid, ex_is_md, stall, md_start, md_abort, md_timeout, illegal, md_op);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mul();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_illegal();
        test_reset_wait();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
